// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of one 2-bit adder among NUM_REQ requesters
module adder
  (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [2:0] data_out
  );
  assign data_out = 3'(a) + 3'(b);
endmodule

module adder_rr_scheduler #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
  ) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_flat,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W+2:0]      rsp_flat,
    output logic                 busy,
    output logic [7:0]           op_count
  );
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, win, cand;
  logic [1:0]      a_q, b_q;
  logic [2:0]      sum;
  logic [3:0]      lane;
  logic [ID_W+2:0] rsp_flat_q;
  logic [7:0]      op_count_q;
  logic            any_v, accept;
  assign any_v     = |req_valid;
  assign accept    = state_q == IDLE && any_v;
  assign lane      = 4'(req_flat >> {win, 2'b00});
  assign ptr_d     = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign req_ready = (accept && !rst) ? NUM_REQ'(1) << win : '0;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_flat  = rsp_flat_q;
  assign op_count  = op_count_q;
  adder u_adder (.a(a_q), .b(b_q), .data_out(sum));
  // winner: first valid lane at or above the pointer, wrapping; lowest offset assigned last wins
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) win = cand;
    end
  end
  // next state: one exec cycle, then hold the response until it is taken
  always_comb begin
    state_d = (state_q == IDLE) ? (any_v ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // capture on grant, register the sum in EXEC, count completed handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_flat_q <= '0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        ptr_q <= ptr_d;
        id_q  <= win;
        a_q   <= lane[3:2];
        b_q   <= lane[1:0];
      end
      if (state_q == EXEC) rsp_flat_q <= {id_q, sum};
      if (state_q == RESP && rsp_ready) op_count_q <= op_count_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: vector table, directed corner cases and randomized model check
module tb_adder_rr_scheduler;
  logic        clk = 0, rst = 1, rsp_ready = 0, rsp_valid, busy;
  logic [3:0]  req_valid = 0, req_ready;
  logic [15:0] req_flat = 0;
  logic [4:0]  rsp_flat;
  logic [7:0]  op_count;
  int checks = 0, failures = 0, m_ptr = 0, exp_cnt = 0;

  adder_rr_scheduler #(.NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flat(req_flat), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_flat(rsp_flat), .busy(busy), .op_count(op_count));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [3:0] v; logic [15:0] f; int id; logic [2:0] s; } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [2:0] lane_sum(input logic [15:0] f, input int w);
    return 3'(((f >> (4 * w + 2)) & 3) + ((f >> (4 * w)) & 3));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req_valid = 0; rsp_ready = 0;
    @(negedge clk);
    rst = 0; m_ptr = 0; exp_cnt = 0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_rsp_flat", 32'(rsp_flat), 0);
  endtask

  task automatic txn(input logic [3:0] v, input logic [15:0] f, input int id, input logic [2:0] s, input int stall);
    logic [4:0] exp_flat;
    exp_flat = {2'(id), s};
    @(negedge clk);
    req_valid = v; req_flat = f; rsp_ready = 0;
    #1 chk("grant", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = 0;
    #1;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 1);
      chk("stall_rsp_flat", 32'(rsp_flat), 32'(exp_flat));
      @(negedge clk);
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_flat", 32'(rsp_flat), 32'(exp_flat));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    exp_cnt = (exp_cnt + 1) % 256;
    m_ptr = (id + 1) % 4;
    #1;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    chk("rsp_flat_held", 32'(rsp_flat), 32'(exp_flat));
  endtask

  initial begin
    int gid[$];
    int gcyc[$];
    tbl[0] = '{4'b0100, 16'hBF96, 2, 3'd6};
    tbl[1] = '{4'b0011, 16'hBF96, 0, 3'd3};
    tbl[2] = '{4'b0011, 16'h0000, 1, 3'd0};
    tbl[3] = '{4'b1111, 16'h5A3C, 2, 3'd4};
    tbl[4] = '{4'b1000, 16'hF000, 3, 3'd6};
    tbl[5] = '{4'b0010, 16'h00E0, 1, 3'd5};
    tbl[6] = '{4'b0001, 16'h000D, 0, 3'd4};

    #1 chk("rst_req_ready", 32'(req_ready), 0);
    do_reset();
    foreach (tbl[i]) txn(tbl[i].v, tbl[i].f, tbl[i].id, tbl[i].s, 0);

    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      req_valid = 4'b1111; req_flat = 16'h1234; rsp_ready = 1;
      #1;
      if (req_ready != 0) begin
        gid.push_back($clog2(int'(req_ready)));
        gcyc.push_back(c);
      end
    end
    @(negedge clk);
    req_valid = 0; rsp_ready = 0;
    exp_cnt += 6; m_ptr = 2;
    #1;
    chk("fair_grants", 32'(gid.size()), 6);
    foreach (gid[i]) begin
      chk("fair_id", 32'(gid[i]), 32'(i % 4));
      chk("fair_cycle", 32'(gcyc[i]), 32'(3 * i));
    end
    chk("fair_busy", 32'(busy), 0);
    chk("fair_op_count", 32'(op_count), 32'(exp_cnt));

    @(negedge clk);
    req_valid = 4'b0010; req_flat = 16'h0090;
    #1 chk("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_flat", 32'(rsp_flat), 32'b01011);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0; exp_cnt++; m_ptr = 2;
    #1;
    chk("bp_done_busy", 32'(busy), 0);
    chk("bp_done_count", 32'(op_count), 32'(exp_cnt));

    @(negedge clk);
    req_valid = 4'b0100; req_flat = 16'h0F00;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #1 chk("ar_pre_rsp_valid", 32'(rsp_valid), 1);
    req_valid = 4'b1111;
    #2 rst = 1;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_op_count", 32'(op_count), 0);
    chk("ar_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 0; req_valid = 0; m_ptr = 0; exp_cnt = 0;
    txn(4'b1001, 16'hB006, 0, 3'd3, 0);
    txn(4'b1001, 16'hB006, 3, 3'd5, 0);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [3:0] v;
      v = 4'(1 << (i % 4));
      txn(v, 16'h7E5B, winner(v), lane_sum(16'h7E5B, winner(v)), 0);
      if (i == 254) chk("wrap_255", 32'(op_count), 255);
      if (i == 255) chk("wrap_0", 32'(op_count), 0);
    end

    for (int i = 0; i < 150; i++) begin
      logic [3:0] v;
      logic [15:0] f;
      v = 4'($urandom_range(0, 15));
      f = 16'($urandom);
      if (v == 0) begin
        @(negedge clk);
        req_valid = 0; req_flat = f;
        #1;
        chk("idle_req_ready", 32'(req_ready), 0);
        chk("idle_busy", 32'(busy), 0);
      end else txn(v, f, winner(v), lane_sum(f, winner(v)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Round-robin scheduler that shares one instance of the team's 2-bit `adder` block (ports a, b, data_out) among NUM_REQ requesters.
- Each requester supplies a 4-bit operand bundle `{a,b}` on a flattened input bus with valid/ready.
- The block arbitrates, captures the winner's operands, drives the shared adder, and returns a tagged 3-bit sum on a single valid/ready response channel.
- It sits between fuzz-harness stimulus lanes and the shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), localparam; width of requester ID tag.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_flat  input  4*NUM_REQ  lane i operands at [4i+3:4i]; a=[4i+3:4i+2], b=[4i+1:4i].
- req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_flat  output  3+ID_W  [2:0]=sum, [ID_W+2:3]=requester ID.
- busy  output  1  high whenever state != IDLE.
- op_count  output  8  completed-response counter.

Behaviour:
- Reset, asynchronous on rst assertion:
  - state=IDLE, rr pointer=0.
  - rsp_valid=0, rsp_flat=0, op_count=0, busy=0.
  - req_ready=0 while rst is high.
  - Any in-flight operation is discarded and never responded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: one-hot of the winner when any req_valid is high, else 0.
  - Winner = first set bit of req_valid searching upward from the pointer, wrapping NUM_REQ-1 -> 0.
  - On a clock edge with any valid: capture winner operands and ID, pointer <= (winner+1) mod NUM_REQ, go to EXEC.
- EXEC:
  - Shared adder driven from the captured operand registers.
  - data_out registered into rsp_flat[2:0]; ID into rsp_flat[ID_W+2:3].
  - Go to RESP. req_ready=0.
- RESP:
  - rsp_valid=1; rsp_flat held stable until rsp_ready.
  - On rsp_valid&rsp_ready edge: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
  - req_ready=0 throughout.
- Latency: accept in cycle T, rsp_valid high from T+2. Earliest next accept is the cycle after response handshake, so minimum 3 cycles per op.
- No bypass: a response handshake and a new grant never occur in the same cycle.
- Arithmetic: unsigned 2b+2b -> 3b, max 6, no truncation.
- op_count wraps 255 -> 0 silently.
- Requesters must hold req_valid and operands until granted. A lane dropping req_valid before grant is simply skipped; no error is flagged.
- Pointer advances only on an actual grant; idle cycles leave it unchanged.
- rsp_flat retains its last value after the handshake until overwritten in the next EXEC.

Test Plan:
- Reset async: rst asserted between clock edges during RESP -> rsp_valid, busy, op_count drop to 0 before the next edge; req_ready=0 while rst is high.
- Single request: req_valid=0100, lane2 a=3, b=3, rsp_ready=1 -> req_ready=0100 in T; rsp_valid in T+2 with rsp_flat={ID=2, sum=6}; op_count=1.
- Fairness: all four req_valid held high, rsp_ready=1 -> grant sequence 0,1,2,3,0,1 with grants every 3 cycles.
- Backpressure: lane1 a=2, b=1, rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_flat={1,3} stable; req_ready=0000; busy=1. Releasing rsp_ready gives a handshake and a return to IDLE.
- Counter wrap: 256 back-to-back transactions -> op_count reads 255 then 0.
- Post-reset priority: reset pulse, then req_valid=1001 -> lane0 granted first, then lane3.
